// File: rtl/a2d_load_intf.sv
// Round-robin SPI master for the 8-channel 12-bit A2D: reads ch0/4/5/6 into lft_ld/rght_ld/steer_pot/batt.
// Define LD_FILT_EN to replace raw lft_ld/rght_ld with a 4-sample moving average.
module a2d_load_intf #(
  parameter int fast_sim = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        vld
);

  typedef enum logic [2:0] {IDLE, XFER1, GAP1, XFER2, GAP2} state_t;

  localparam logic [19:0] PERIOD_M1 = (fast_sim != 0) ? 20'd8191 : 20'hFFFFF;
  localparam logic [9:0]  XFER_LAST = 10'd520;
  localparam logic [9:0]  GAP_LAST  = 10'd31;
  // Preload so the divider MSB drops 9 clk after SS_n falls, then toggles every 16 clk.
  localparam logic [4:0]  DIV_INIT  = 5'd23;

  function automatic logic [2:0] chan_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'd0;
      2'd1:    return 3'd4;
      2'd2:    return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [4:0]  div_q, div_d;
  logic [15:0] shreg_q, shreg_d;
  logic        sclk_q, sclk_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic [1:0]  ch_q, ch_d;
  logic [19:0] timer_q, timer_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] steer_q, steer_d;
  logic [11:0] batt_q, batt_d;
  logic        batt_done_q, batt_done_d;
  logic        vld_q, vld_d;
  logic        start_xfer;
  logic [11:0] raw;

`ifdef LD_FILT_EN
  logic [11:0] lft_hist_q [4];
  logic [11:0] lft_hist_d [4];
  logic [11:0] rght_hist_q [4];
  logic [11:0] rght_hist_d [4];
  logic        lft_filled_q, lft_filled_d;
  logic        rght_filled_q, rght_filled_d;

  function automatic logic [11:0] avg4(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c, input logic [11:0] d);
    logic [13:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return 12'(s >> 2);
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    shreg_d     = shreg_q;
    sclk_d      = sclk_q;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    ch_d        = ch_q;
    lft_d       = lft_q;
    rght_d      = rght_q;
    steer_d     = steer_q;
    batt_d      = batt_q;
    batt_done_d = 1'b0;
    vld_d       = batt_done_q;
    start_xfer  = 1'b0;
    raw         = shreg_q[11:0];
    timer_d     = (timer_q == PERIOD_M1) ? 20'd0 : timer_q + 20'd1;
`ifdef LD_FILT_EN
    lft_hist_d    = lft_hist_q;
    rght_hist_d   = rght_hist_q;
    lft_filled_d  = lft_filled_q;
    rght_filled_d = rght_filled_q;
`endif

    case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        // A wrap that lands mid-round is never seen here, so it is simply dropped.
        if (timer_q == 20'd0) begin
          state_d    = XFER1;
          ch_d       = 2'd0;
          start_xfer = 1'b1;
        end
      end

      XFER1, XFER2: begin
        cnt_d  = cnt_q + 10'd1;
        div_d  = div_q + 5'd1;
        sclk_d = div_d[4];
        if (cnt_q == XFER_LAST) begin
          ss_n_d  = 1'b1;
          sclk_d  = 1'b1;
          cnt_d   = 10'd0;
          state_d = (state_q == XFER1) ? GAP1 : GAP2;
          if (state_q == XFER2) begin
            case (ch_q)
              2'd0: begin
`ifdef LD_FILT_EN
                for (int j = 3; j > 0; j--)
                  lft_hist_d[j] = lft_filled_q ? lft_hist_q[j-1] : raw;
                lft_hist_d[0] = raw;
                lft_filled_d  = 1'b1;
                lft_d = avg4(lft_hist_d[0], lft_hist_d[1], lft_hist_d[2], lft_hist_d[3]);
`else
                lft_d = raw;
`endif
              end
              2'd1: begin
`ifdef LD_FILT_EN
                for (int j = 3; j > 0; j--)
                  rght_hist_d[j] = rght_filled_q ? rght_hist_q[j-1] : raw;
                rght_hist_d[0] = raw;
                rght_filled_d  = 1'b1;
                rght_d = avg4(rght_hist_d[0], rght_hist_d[1], rght_hist_d[2], rght_hist_d[3]);
`else
                rght_d = raw;
`endif
              end
              2'd2: steer_d = raw;
              default: begin
                batt_d      = raw;
                batt_done_d = 1'b1;
              end
            endcase
          end
        end
        // MOSI moves on SCLK falls; MISO is captured as SCLK rises.
        if (sclk_q && !sclk_d) mosi_d = shreg_q[15];
        if (!sclk_q && sclk_d) shreg_d = {shreg_q[14:0], MISO};
      end

      GAP1: begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        cnt_d  = cnt_q + 10'd1;
        if (cnt_q == GAP_LAST) begin
          state_d    = XFER2;
          start_xfer = 1'b1;
        end
      end

      GAP2: begin
        ss_n_d = 1'b1;
        sclk_d = 1'b1;
        cnt_d  = cnt_q + 10'd1;
        if (cnt_q == GAP_LAST) begin
          if (ch_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            ch_d       = ch_q + 2'd1;
            state_d    = XFER1;
            start_xfer = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        ss_n_d  = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase

    if (start_xfer) begin
      ss_n_d  = 1'b0;
      sclk_d  = 1'b1;
      cnt_d   = 10'd0;
      div_d   = DIV_INIT;
      shreg_d = {2'b00, chan_of(ch_d), 11'h000};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 10'd0;
      div_q       <= DIV_INIT;
      shreg_q     <= 16'h0000;
      sclk_q      <= 1'b1;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ch_q        <= 2'd0;
      timer_q     <= 20'd0;
      lft_q       <= 12'h000;
      rght_q      <= 12'h000;
      steer_q     <= 12'h000;
      batt_q      <= 12'h000;
      batt_done_q <= 1'b0;
      vld_q       <= 1'b0;
`ifdef LD_FILT_EN
      for (int j = 0; j < 4; j++) begin
        lft_hist_q[j]  <= 12'h000;
        rght_hist_q[j] <= 12'h000;
      end
      lft_filled_q  <= 1'b0;
      rght_filled_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      shreg_q     <= shreg_d;
      sclk_q      <= sclk_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      ch_q        <= ch_d;
      timer_q     <= timer_d;
      lft_q       <= lft_d;
      rght_q      <= rght_d;
      steer_q     <= steer_d;
      batt_q      <= batt_d;
      batt_done_q <= batt_done_d;
      vld_q       <= vld_d;
`ifdef LD_FILT_EN
      for (int j = 0; j < 4; j++) begin
        lft_hist_q[j]  <= lft_hist_d[j];
        rght_hist_q[j] <= rght_hist_d[j];
      end
      lft_filled_q  <= lft_filled_d;
      rght_filled_q <= rght_filled_d;
`endif
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign vld       = vld_q;

endmodule

// File: tb/tb_a2d_load_intf.sv
// Directed bench for a2d_load_intf with a behavioural A2D on the SPI pins.
module tb_a2d_load_intf;

  logic        clk;
  logic        rst;
  logic        MISO;
  logic        SS_n, SCLK, MOSI, vld;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  a2d_load_intf #(.fast_sim(1)) dut (
    .clk(clk), .rst(rst), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt), .vld(vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // A2D model and SPI waveform recorder, evaluated mid-cycle.
  int          fall_t[$];
  int          lo_len[$];
  int          hi_len[$];
  int          nfalls[$];
  logic [15:0] cmds[$];
  logic        ss_prev, sclk_prev, seen_rise, use_lft;
  int          lo_cnt, hi_cnt, falls_cur, bidx;
  logic [15:0] mosi_sh, resp;
  logic [2:0]  last_ch;
  logic [11:0] lft_val;

  initial begin
    MISO = 1'b0; ss_prev = 1'b1; sclk_prev = 1'b1; seen_rise = 1'b0;
    lo_cnt = 0; hi_cnt = 0; falls_cur = 0; bidx = -1;
    mosi_sh = '0; resp = '0; last_ch = '0;
    forever begin
      @(negedge clk);
      if (ss_prev && !SS_n) begin
        fall_t.push_back(cyc);
        if (seen_rise) hi_len.push_back(hi_cnt);
        lo_cnt = 0; falls_cur = 0; mosi_sh = '0; bidx = 15;
        if (use_lft && last_ch == 3'd0) resp = {4'hF, lft_val};
        else resp = 16'hF000 | (16'(last_ch) << 8) | 16'h005A;
      end
      if (!ss_prev && SS_n) begin
        lo_len.push_back(lo_cnt);
        nfalls.push_back(falls_cur);
        cmds.push_back(mosi_sh);
        last_ch = mosi_sh[13:11];
        hi_cnt = 0;
        seen_rise = 1'b1;
      end
      if (!SS_n) begin
        lo_cnt++;
        if (sclk_prev && !SCLK) begin
          falls_cur++;
          if (bidx >= 0) MISO = resp[bidx];
          bidx--;
        end
        if (!sclk_prev && SCLK) mosi_sh = {mosi_sh[14:0], MOSI};
      end else begin
        hi_cnt++;
      end
      ss_prev = SS_n;
      sclk_prev = SCLK;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(input int limit, output int t);
    t = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (vld === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic clear_log();
    fall_t.delete(); lo_len.delete(); hi_len.delete(); nfalls.delete(); cmds.delete();
  endtask

  int          t_start, t_vld, k, f0;
  int          chs[8] = '{0, 0, 4, 4, 5, 5, 6, 6};
  logic [15:0] ecmd;
`ifdef LD_FILT_EN
  int          exp_lft[4] = '{400, 500, 600, 700};
`else
  int          exp_lft[4] = '{400, 800, 800, 800};
`endif

  initial begin
    rst = 1'b1; use_lft = 1'b0; lft_val = 12'd0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_data", {lft_ld, rght_ld, steer_pot, batt}, 0);
    chk("rst_vld", vld, 0);

    rst = 1'b0;
    for (k = 0; k < 3 && SS_n !== 1'b0; k++) @(negedge clk);
    k = (SS_n === 1'b0) ? k : 99;
    chk("ss_fall_after_rst", (k >= 1 && k <= 2), 1);

    // Round 1: fixed A2D pattern, timing and waveform.
    wait_vld(9000, t_vld);
    chk("vld_seen_r1", (t_vld >= 0), 1);
    t_start = (fall_t.size() > 0) ? fall_t[0] : -1;
    chk("vld_latency", t_vld - t_start, 4393);
    chk("lft_ld", lft_ld, 12'h05A);
    chk("rght_ld", rght_ld, 12'h45A);
    chk("steer_pot", steer_pot, 12'h55A);
    chk("batt", batt, 12'h65A);
    @(negedge clk);
    chk("vld_one_cycle", vld, 0);

    chk("xfer_count", cmds.size(), 8);
    for (int i = 0; i < 8 && i < cmds.size(); i++) begin
      ecmd = 16'(chs[i]) << 11;
      $display("xfer %0d cmd=%04h low=%0d sclk_falls=%0d", i, cmds[i], lo_len[i], nfalls[i]);
      chk($sformatf("mosi_cmd%0d", i), cmds[i], ecmd);
      chk($sformatf("sclk_falls%0d", i), nfalls[i], 16);
      chk($sformatf("ss_low%0d", i), lo_len[i], 521);
    end
    chk("gap_count", hi_len.size(), 7);
    for (int i = 0; i < 7 && i < hi_len.size(); i++)
      chk($sformatf("gap%0d", i), hi_len[i], 32);

    // Round 2 must start exactly one period after round 1.
    clear_log();
    for (k = 0; k < 9000 && fall_t.size() == 0; k++) @(negedge clk);
    f0 = (fall_t.size() > 0) ? fall_t[0] : -1;
    chk("round_period", f0 - t_start, 8192);
    chk("idle_high", (hi_len.size() > 0) ? hi_len[0] : -1, 3800);

    // Abort during the 8th bit of the rght_ld second transaction.
    for (k = 0; k < 3000 && fall_t.size() < 4; k++) @(negedge clk);
    for (k = 0; k < 600 && falls_cur < 8; k++) @(negedge clk);
    chk("reached_rght_xfer2_bit8", (fall_t.size() == 4 && falls_cur == 8), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ss_n", SS_n, 1);
    chk("mid_rst_sclk", SCLK, 1);
    chk("mid_rst_rght", rght_ld, 12'h000);
    @(negedge clk);
    clear_log();
    use_lft = 1'b1;
    lft_val = 12'd400;
    rst = 1'b0;

    // Rounds after reset: restart at channel 0 and feed lft_ld 400, 800, 800, 800.
    for (int r = 0; r < 4; r++) begin
      wait_vld(9000, t_vld);
      chk($sformatf("vld_seen_f%0d", r), (t_vld >= 0), 1);
      if (r == 0) begin
        chk("restart_ch0", (cmds.size() > 0) ? cmds[0] : 16'hFFFF, 16'h0000);
        chk("restart_latency", t_vld - ((fall_t.size() > 0) ? fall_t[0] : -1), 4393);
      end
      $display("round %0d lft_ld=%0d rght_ld=%03h", r, lft_ld, rght_ld);
      chk($sformatf("lft_seq%0d", r), lft_ld, 12'(exp_lft[r]));
      chk($sformatf("rght_seq%0d", r), rght_ld, 12'h45A);
      lft_val = 12'd800;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
